// File: rtl/qam_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : qam_bit_packer
// Brief    : Packs 16-QAM demapped symbols into framed words behind a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module qam_bit_packer #(
    parameter int SYM_BITS       = 4,
    parameter int WORD_W         = 16,
    parameter int SYMS_PER_FRAME = 48,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SYM_BITS-1:0] in_bits,
    input  logic                in_sof,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_last,
    output logic                sof_err,
    output logic [7:0]          frame_cnt
);

    localparam int C_SPW    = WORD_W / SYM_BITS;
    localparam int C_LANE_W = (C_SPW > 1) ? $clog2(C_SPW) : 1;
    localparam int C_CNT_W  = $clog2(SYMS_PER_FRAME + 1);
    localparam int C_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_OCC_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [C_LANE_W-1:0] C_LANE_LAST = C_LANE_W'(C_SPW - 1);
    localparam logic [C_CNT_W-1:0]  C_SYM_LAST  = C_CNT_W'(SYMS_PER_FRAME - 1);
    localparam logic [C_OCC_W-1:0]  C_OCC_FULL  = C_OCC_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PACK = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]          state_q,     state_d;
    logic [C_LANE_W-1:0] lane_q,      lane_d;
    logic [C_CNT_W-1:0]  sym_cnt_q,   sym_cnt_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                sof_err_q,   sof_err_d;
    // The final lane never needs storage: it completes the word in the same cycle.
    logic [SYM_BITS-1:0] sym_q [C_SPW-1];
    logic [SYM_BITS-1:0] sym_d [C_SPW-1];

    logic [WORD_W:0]     mem_q [FIFO_DEPTH];
    logic [WORD_W:0]     mem_d [FIFO_DEPTH];
    logic [C_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [C_OCC_W-1:0]  occ_q,    occ_d;

    logic                w_accept;
    logic                w_completing;
    logic                w_full;
    logic                w_push;
    logic                w_push_last;
    logic                w_pop;
    logic [WORD_W-1:0]   w_word;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    always_comb begin
        w_full       = (occ_q == C_OCC_FULL);
        w_completing = (state_q == ST_PACK) && (lane_q == C_LANE_LAST) && !in_sof;
        in_ready     = rst_n && !(w_full && w_completing);
        w_accept     = in_valid && in_ready;
    end

    // Earliest symbol lands in the most significant lane.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < C_SPW - 1; i++) begin
            w_word[WORD_W-1-i*SYM_BITS -: SYM_BITS] = sym_q[i];
        end
        w_word[SYM_BITS-1:0] = in_bits;
    end

    // ------------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        sym_cnt_d   = sym_cnt_q;
        frame_cnt_d = frame_cnt_q;
        sof_err_d   = 1'b0;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        for (int i = 0; i < C_SPW - 1; i++) begin
            sym_d[i] = sym_q[i];
        end

        if (w_accept) begin
            if (in_sof) begin
                // A new start always wins; any partial word of an open frame is dropped.
                sof_err_d = (state_q == ST_PACK);
                sym_d[0]  = in_bits;
                lane_d    = C_LANE_W'(1);
                sym_cnt_d = C_CNT_W'(1);
                state_d   = ST_PACK;
            end else if (state_q == ST_PACK) begin
                for (int i = 0; i < C_SPW - 1; i++) begin
                    if (lane_q == C_LANE_W'(i)) begin
                        sym_d[i] = in_bits;
                    end
                end
                if (lane_q == C_LANE_LAST) begin
                    w_push      = 1'b1;
                    w_push_last = (sym_cnt_q == C_SYM_LAST);
                    lane_d      = '0;
                    if (w_push_last) begin
                        state_d     = ST_IDLE;
                        sym_cnt_d   = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end else begin
                    lane_d    = lane_q + 1'b1;
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid = (occ_q != '0);
        w_pop     = out_valid && out_ready;
        out_data  = out_valid ? mem_q[rd_ptr_q][WORD_W-1:0] : '0;
        out_last  = out_valid ? mem_q[rd_ptr_q][WORD_W]     : 1'b0;

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = {w_push_last, w_word};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    assign sof_err   = sof_err_q;
    assign frame_cnt = frame_cnt_q;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            sym_cnt_q   <= '0;
            frame_cnt_q <= '0;
            sof_err_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            for (int i = 0; i < C_SPW - 1; i++) begin
                sym_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            sym_cnt_q   <= sym_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sof_err_q   <= sof_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            for (int i = 0; i < C_SPW - 1; i++) begin
                sym_q[i] <= sym_d[i];
            end
        end
    end

    // Storage needs no reset: entries are only observable while occupancy is non-zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qam_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_bit_packer
// Brief    : Randomized scoreboard bench for qam_bit_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_bit_packer;

    localparam int SPW   = 4;
    localparam int SYMS  = 48;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [3:0]  in_bits = 4'h0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        sof_err;
    logic [7:0]  frame_cnt;

    qam_bit_packer #(
        .SYM_BITS(4), .WORD_W(16), .SYMS_PER_FRAME(SYMS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sof_err(sof_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void check(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: a frame is a list of symbols; every SPW collected
    // symbols form one word, MSB-first. Occupancy = words pushed - words popped.
    // ------------------------------------------------------------------------
    logic [16:0] exp_q[$];
    logic [3:0]  part[$];
    bit          in_frame = 0;
    int          idx = 0;
    int          occ = 0;
    bit          exp_err = 0;
    logic [7:0]  exp_fc = 8'd0;
    int          words_seen = 0;
    int          lasts_seen = 0;

    always @(negedge clk) begin : monitor
        bit          acc;
        bit          pop;
        bit          push;
        bit          exp_rdy;
        logic [16:0] w;
        if (!rst_n) begin
            check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
            check(in_ready == 1'b0,  "rst_in_ready",  in_ready, 0);
            check(out_data == 16'h0, "rst_out_data",  out_data, 0);
            check(out_last == 1'b0,  "rst_out_last",  out_last, 0);
            check(sof_err == 1'b0,   "rst_sof_err",   sof_err, 0);
            check(frame_cnt == 8'h0, "rst_frame_cnt", frame_cnt, 0);
            exp_q.delete();
            part.delete();
            in_frame = 0;
            idx      = 0;
            occ      = 0;
            exp_err  = 0;
            exp_fc   = 8'd0;
        end else begin
            exp_rdy = !(occ == DEPTH && in_frame && part.size() == SPW - 1 && !in_sof);
            check(in_ready == exp_rdy,        "in_ready",  in_ready, exp_rdy);
            check(out_valid == (occ != 0),    "out_valid", out_valid, occ != 0);
            check(sof_err == exp_err,         "sof_err",   sof_err, exp_err);
            check(frame_cnt == exp_fc,        "frame_cnt", frame_cnt, exp_fc);
            if (occ != 0) begin
                if (exp_q.size() == 0)
                    check(1'b0, "scoreboard_underflow", {out_last, out_data}, 0);
                else
                    check({out_last, out_data} == exp_q[0], "out_word", {out_last, out_data}, exp_q[0]);
            end
            pop = (occ != 0) && out_ready;
            if (pop && exp_q.size() != 0) begin
                if (exp_q[0][16]) lasts_seen++;
                words_seen++;
                void'(exp_q.pop_front());
            end
            acc     = in_valid && in_ready;
            push    = 0;
            exp_err = 0;
            if (acc) begin
                if (in_sof) begin
                    exp_err = in_frame;
                    part.delete();
                    part.push_back(in_bits);
                    idx      = 1;
                    in_frame = 1;
                end else if (in_frame) begin
                    part.push_back(in_bits);
                    idx++;
                    if (part.size() == SPW) begin
                        w = '0;
                        foreach (part[i]) w[15:0] = {w[11:0], part[i]};
                        w[16] = (idx == SYMS);
                        exp_q.push_back(w);
                        push = 1;
                        part.delete();
                        if (idx == SYMS) begin
                            in_frame = 0;
                            exp_fc   = exp_fc + 8'd1;
                        end
                    end
                end
            end
            occ = occ + int'(push) - int'(pop);
        end
    end

    // ------------------------------------------------------------------------
    // Consumer: 0 = stall, 1 = always ready, 2 = random
    // ------------------------------------------------------------------------
    int rmode = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input logic [3:0] b, input bit s, input int gap);
        int  w = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_bits  = b;
        in_sof   = s;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else begin
                w++;
                if (w > TMO) begin
                    check(1'b0, "accept_timeout", w, TMO);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // off < 0 gives random symbol values, otherwise (i + off) mod 16
    task automatic frame(input int n, input int off, input int maxgap);
        logic [3:0] b;
        for (int i = 0; i < n; i++) begin
            b = (off < 0) ? 4'($urandom) : 4'((i + off) % 16);
            send(b, i == 0, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic drain();
        int w = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        while (out_valid && w < TMO) begin
            @(negedge clk);
            w++;
        end
        check(!out_valid, "drain", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w0;
        int l0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rmode = 1;

        // Counting frame, free-flowing output
        w0 = words_seen; l0 = lasts_seen;
        frame(SYMS, 0, 0);
        drain();
        check(words_seen - w0 == 12, "t1_words", words_seen - w0, 12);
        check(lasts_seen - l0 == 1,  "t1_lasts", lasts_seen - l0, 1);
        check(frame_cnt == 8'd1,     "t1_frame_cnt", frame_cnt, 1);

        // Backpressure: stalled consumer, single pop, then release
        rmode = 0;
        fork
            frame(SYMS, 0, 0);
            begin
                repeat (40) @(posedge clk);
                rmode = 1;
                @(posedge clk);
                rmode = 0;
                repeat (20) @(posedge clk);
                rmode = 1;
            end
        join
        drain();
        check(frame_cnt == 8'd2, "t2_frame_cnt", frame_cnt, 2);

        // Early start-of-frame at symbol index 10
        w0 = words_seen;
        frame(10, 0, 0);
        frame(SYMS, 10, 0);
        drain();
        check(words_seen - w0 == 14, "t3_words", words_seen - w0, 14);
        check(frame_cnt == 8'd3,     "t3_frame_cnt", frame_cnt, 3);

        // Symbols without start-of-frame are dropped in IDLE
        for (int i = 0; i < 20; i++) send(4'(i), 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!out_valid,        "t4_no_output", out_valid, 0);
        check(frame_cnt == 8'd3, "t4_frame_cnt", frame_cnt, 3);
        @(posedge clk);
        #1;

        // Reset mid-frame with three words queued
        rmode = 0;
        frame(13, -1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check(!out_valid && !in_ready, "t5_async_clear", {out_valid, in_ready}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rmode = 1;
        frame(SYMS, -1, 0);
        drain();
        check(frame_cnt == 8'd1, "t5_frame_cnt", frame_cnt, 1);

        // 256 frames: counter wraps back to its starting value
        l0 = lasts_seen;
        rmode = 2;
        for (int f = 0; f < 256; f++) frame(SYMS, -1, 0);
        rmode = 1;
        drain();
        check(lasts_seen - l0 == 256, "t6_lasts", lasts_seen - l0, 256);
        check(frame_cnt == 8'd1,      "t6_frame_wrap", frame_cnt, 1);

        // Random traffic with occasional restarts and idle gaps
        rmode = 2;
        for (int i = 0; i < 1500; i++) begin
            send(4'($urandom), (i == 0) || ($urandom_range(0, 39) == 0), int'($urandom_range(0, 2)));
        end
        rmode = 1;
        drain();
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
